// File: rtl/axis_uart_tx_arbiter.sv
// axis_uart_tx_arbiter
// Packet-level round-robin arbiter that shares one AXI-Stream UART transmit
// path among N_REQ requesters. A grant is held from the first beat of a packet
// until a beat carrying last is accepted, so packets never interleave. Packets
// longer than MAX_BEATS are cut: the capping beat is marked last and the rest
// of the source packet is re-arbitrated as a fresh packet.
//
// Optional feature macro: UART_ARB_TAG_EN
//   When defined, every granted packet is preceded by one header beat
//   (TAG_BASE | grant index, last=0) that does not count toward MAX_BEATS.
//   When undefined, the header state and its data path are not built.
module axis_uart_tx_arbiter #(
  parameter int                WIDTH     = 8,
  parameter int                N_REQ     = 4,
  parameter int                MAX_BEATS = 64,
  parameter logic [WIDTH-1:0]  TAG_BASE  = WIDTH'(8'hF0)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ*WIDTH-1:0]     s_axis_data,
  input  logic [N_REQ-1:0]           s_axis_valid,
  input  logic [N_REQ-1:0]           s_axis_last,
  output logic [N_REQ-1:0]           s_axis_ready,
  output logic [WIDTH-1:0]           m_axis_data,
  output logic                       m_axis_valid,
  output logic                       m_axis_last,
  input  logic                       m_axis_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int GID_W = $clog2(N_REQ);
  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TAG = 2'd1, S_PASS = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PASS = 2'd2} state_t;
`endif

  state_t             r_state;
  logic [GID_W-1:0]   r_grant;
  logic [GID_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic               r_busy;

  logic [GID_W-1:0]   w_pick;
  logic               w_found;
  logic               w_accept;

`ifndef UART_ARB_TAG_EN
  // The header base is only meaningful when tagging is built in.
  logic               w_unused_tag;
  assign w_unused_tag = ^TAG_BASE;
`endif

  // Lane index reached by stepping 'off' positions forward from 'base', wrapping at N_REQ.
  function automatic logic [GID_W-1:0] rr_index(input logic [GID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return GID_W'(s);
  endfunction

  assign grant_id = r_grant;
  assign busy     = r_busy;

  // Round-robin pick: first requesting lane at or after the rotation pointer.
  always_comb begin
    w_pick  = r_rr_ptr;
    w_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && s_axis_valid[rr_index(r_rr_ptr, i)]) begin
        w_pick  = rr_index(r_rr_ptr, i);
        w_found = 1'b1;
      end
    end
  end

  // Output steering: idle is silent, pass connects the granted lane straight through.
  always_comb begin
    m_axis_valid = 1'b0;
    m_axis_data  = '0;
    m_axis_last  = 1'b0;
    s_axis_ready = '0;
    case (r_state)
`ifdef UART_ARB_TAG_EN
      S_TAG: begin
        m_axis_valid = 1'b1;
        m_axis_data  = TAG_BASE | WIDTH'(r_grant);
      end
`endif
      S_PASS: begin
        m_axis_valid          = s_axis_valid[r_grant];
        m_axis_data           = s_axis_data[int'(r_grant)*WIDTH +: WIDTH];
        m_axis_last           = s_axis_last[r_grant] | (r_beat_cnt == CNT_LAST);
        s_axis_ready[r_grant] = m_axis_ready;
      end
      default: ;
    endcase
  end

  assign w_accept = m_axis_valid & m_axis_ready;

  // Arbitration FSM: grant held until a last beat is accepted, then the pointer rotates past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant    <= w_pick;
            r_beat_cnt <= '0;
            r_busy     <= 1'b1;
`ifdef UART_ARB_TAG_EN
            r_state    <= S_TAG;
`else
            r_state    <= S_PASS;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        S_TAG: begin
          if (m_axis_ready) r_state <= S_PASS;
        end
`endif
        S_PASS: begin
          if (w_accept) begin
            if (m_axis_last) begin
              r_rr_ptr   <= rr_index(r_grant, 1);
              r_beat_cnt <= '0;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
